// File: rtl/pipe_pkg.sv
// Shared encodings for the trace pipeline: write-back select, forwarding
// source select and the hazard controller FSM states.
package pipe_pkg;

    localparam logic [1:0] WD_ALU   = 2'b00;
    localparam logic [1:0] LOAD_SEL = 2'b01;
    localparam logic [1:0] WD_PC4   = 2'b10;
    localparam logic [1:0] WD_IMM   = 2'b11;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        MEM_WAIT = 2'b01,
        ERR      = 2'b10
    } hz_state_t;

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_unit.sv
// EX-stage operand forwarding selection; the younger (MEM) result wins over WB.
module fwd_unit
    import pipe_pkg::*;
(
    input  logic [4:0] ex_rs1,
    input  logic [4:0] ex_rs2,
    input  logic [4:0] mem_wR,
    input  logic       mem_rf_we,
    input  logic [4:0] wb_wR,
    input  logic       wb_rf_we,
    output logic [1:0] fwd1_sel,
    output logic [1:0] fwd2_sel
);

    function automatic logic [1:0] pick_src(
        input logic [4:0] rs,
        input logic [4:0] m_wr,
        input logic       m_we,
        input logic [4:0] w_wr,
        input logic       w_we
    );
        logic [1:0] sel;
        if (m_we && (m_wr != 5'd0) && (m_wr == rs)) begin
            sel = FWD_EXMEM;
        end else if (w_we && (w_wr != 5'd0) && (w_wr == rs)) begin
            sel = FWD_MEMWB;
        end else begin
            sel = FWD_RF;
        end
        return sel;
    endfunction

    // Per-operand source selection
    always_comb begin
        fwd1_sel = pick_src(ex_rs1, mem_wR, mem_rf_we, wb_wR, wb_rf_we);
        fwd2_sel = pick_src(ex_rs2, mem_wR, mem_rf_we, wb_wR, wb_rf_we);
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush/forward controller for the 5-stage trace pipeline.
// Optional performance counters are built when HAZARD_PERF_EN is defined.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
`ifdef HAZARD_PERF_EN
    ,
    parameter int CNT_W = 32
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_re1,
    input  logic             id_re2,
    input  logic [4:0]       ex_rs1,
    input  logic [4:0]       ex_rs2,
    input  logic [4:0]       ex_wR,
    input  logic             ex_rf_we,
    input  logic [1:0]       ex_wd_sel,
    input  logic             ex_br_taken,
    input  logic [4:0]       mem_wR,
    input  logic             mem_rf_we,
    input  logic             mem_req,
    input  logic             dram_ready,
    input  logic [4:0]       wb_wR,
    input  logic             wb_rf_we,
    output logic             pc_stall,
    output logic             ifid_stall,
    output logic             ifid_flush,
    output logic             idex_stall,
    output logic             idex_flush,
    output logic             exmem_stall,
    output logic             memwb_flush,
    output logic [1:0]       fwd1_sel,
    output logic [1:0]       fwd2_sel,
`ifdef HAZARD_PERF_EN
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events,
    output logic [CNT_W-1:0] mem_wait_cycles,
`endif
    output logic             halted
);

    localparam int              WAIT_W    = $clog2(MEM_TIMEOUT) + 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX  = {WAIT_W{1'b1}};

    hz_state_t         state_r, state_nxt_s;
    logic [WAIT_W-1:0] wait_cnt_r, wait_cnt_nxt_s;
    logic              halted_r, halted_nxt_s;

    logic pc_stall_s, ifid_stall_s, ifid_flush_s, idex_stall_s;
    logic idex_flush_s, exmem_stall_s, memwb_flush_s;
    logic mem_freeze_s, load_use_s;
    logic [1:0] fwd1_raw_s, fwd2_raw_s;

    fwd_unit u_fwd (
        .ex_rs1    (ex_rs1),
        .ex_rs2    (ex_rs2),
        .mem_wR    (mem_wR),
        .mem_rf_we (mem_rf_we),
        .wb_wR     (wb_wR),
        .wb_rf_we  (wb_rf_we),
        .fwd1_sel  (fwd1_raw_s),
        .fwd2_sel  (fwd2_raw_s)
    );

    // Load-use: ID reads the register the load in EX is about to produce
    always_comb begin
        load_use_s = ex_rf_we && (ex_wd_sel == LOAD_SEL) && (ex_wR != 5'd0) &&
                     ((id_re1 && (id_rs1 == ex_wR)) || (id_re2 && (id_rs2 == ex_wR)));
    end

    // Next-state and raw control generation
    always_comb begin
        state_nxt_s    = state_r;
        wait_cnt_nxt_s = wait_cnt_r;
        halted_nxt_s   = halted_r;
        pc_stall_s     = 1'b0;
        ifid_stall_s   = 1'b0;
        ifid_flush_s   = 1'b0;
        idex_stall_s   = 1'b0;
        idex_flush_s   = 1'b0;
        exmem_stall_s  = 1'b0;
        memwb_flush_s  = 1'b0;
        mem_freeze_s   = 1'b0;

        case (state_r)
            RUN, MEM_WAIT: begin
                // A waiting DRAM access freezes everything; a branch held in
                // EX only acts once the freeze lifts.
                if (mem_req && !dram_ready && (state_r == RUN)) begin
                    mem_freeze_s   = 1'b1;
                    state_nxt_s    = MEM_WAIT;
                    wait_cnt_nxt_s = WAIT_W'(1);
                end else if (!dram_ready && (state_r == MEM_WAIT)) begin
                    mem_freeze_s = 1'b1;
                    if (wait_cnt_r == WAIT_LAST) begin
                        state_nxt_s  = ERR;
                        halted_nxt_s = 1'b1;
                    end else if (wait_cnt_r != WAIT_MAX) begin
                        wait_cnt_nxt_s = wait_cnt_r + WAIT_W'(1);
                    end else begin
                        wait_cnt_nxt_s = wait_cnt_r;
                    end
                end else begin
                    state_nxt_s    = RUN;
                    wait_cnt_nxt_s = '0;
                    if (ex_br_taken) begin
                        ifid_flush_s = 1'b1;
                        idex_flush_s = 1'b1;
                    end else if (load_use_s) begin
                        pc_stall_s   = 1'b1;
                        ifid_stall_s = 1'b1;
                        idex_flush_s = 1'b1;
                    end else begin
                        pc_stall_s   = 1'b0;
                    end
                end

                if (mem_freeze_s) begin
                    pc_stall_s    = 1'b1;
                    ifid_stall_s  = 1'b1;
                    idex_stall_s  = 1'b1;
                    exmem_stall_s = 1'b1;
                    memwb_flush_s = 1'b1;
                end else begin
                    memwb_flush_s = 1'b0;
                end
            end
            ERR: begin
                pc_stall_s    = 1'b1;
                ifid_stall_s  = 1'b1;
                idex_stall_s  = 1'b1;
                exmem_stall_s = 1'b1;
                memwb_flush_s = 1'b1;
                halted_nxt_s  = 1'b1;
            end
            default: begin
                state_nxt_s    = RUN;
                wait_cnt_nxt_s = '0;
            end
        endcase
    end

    // Reset overrides every control output combinationally
    always_comb begin
        if (rst) begin
            pc_stall    = 1'b0;
            ifid_stall  = 1'b0;
            ifid_flush  = 1'b0;
            idex_stall  = 1'b0;
            idex_flush  = 1'b0;
            exmem_stall = 1'b0;
            memwb_flush = 1'b0;
            fwd1_sel    = FWD_RF;
            fwd2_sel    = FWD_RF;
        end else begin
            pc_stall    = pc_stall_s;
            ifid_stall  = ifid_stall_s;
            ifid_flush  = ifid_flush_s;
            idex_stall  = idex_stall_s;
            idex_flush  = idex_flush_s;
            exmem_stall = exmem_stall_s;
            memwb_flush = memwb_flush_s;
            fwd1_sel    = fwd1_raw_s;
            fwd2_sel    = fwd2_raw_s;
        end
    end

    // FSM state, wait counter and sticky timeout flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= RUN;
            wait_cnt_r <= '0;
            halted_r   <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            wait_cnt_r <= wait_cnt_nxt_s;
            halted_r   <= halted_nxt_s;
        end
    end

    assign halted = halted_r;

`ifdef HAZARD_PERF_EN
    // Free-running wrap-around performance counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles    <= '0;
            flush_events    <= '0;
            mem_wait_cycles <= '0;
        end else begin
            if (pc_stall) begin
                stall_cycles <= stall_cycles + CNT_W'(1);
            end
            if (ifid_flush) begin
                flush_events <= flush_events + CNT_W'(1);
            end
            if (mem_freeze_s) begin
                mem_wait_cycles <= mem_wait_cycles + CNT_W'(1);
            end
        end
    end
`endif

endmodule
